bin_to_gray_stream: RTL and testbench
=====================================

BIN_TO_GRAY_STREAM -- requirements
Module: bin_to_gray_stream

Interface
REQ-001 Parameter: WIDTH, 4, code width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_bin holds a word to convert.
REQ-005 in_bin  input  WIDTH  binary input word.
REQ-006 in_ready  output  1  block accepts in_bin this cycle.
REQ-007 out_valid  output  1  out_gray holds a valid Gray word.
REQ-008 out_gray  output  WIDTH  registered Gray-coded output.
REQ-009 out_ready  input  1  downstream accepts out_gray this cycle.
REQ-010 cnt_en  input  1  1 = source is the internal counter; 0 = source is in_bin.
REQ-011 cnt_clr  input  1  synchronous clear of the internal counter.
REQ-012 cnt_bin  output  WIDTH  current internal binary counter value.

Function
REQ-013 Conversion SHALL be gray[i] = bin[i] ^ bin[i+1] for i < WIDTH-1, and gray[WIDTH-1] = bin[WIDTH-1].
REQ-014 The output SHALL be a single register stage; "slot free" = !out_valid || out_ready.
REQ-015 in_ready SHALL be combinational: !rst && !cnt_en && slot free.
REQ-016 Stream transfer: in_valid && in_ready at edge N SHALL load out_gray = gray(in_bin) and set out_valid = 1 after edge N (latency 1 cycle).
REQ-017 An output handshake (out_valid && out_ready) with no new load in the same cycle SHALL clear out_valid after that edge.
REQ-018 Simultaneous output handshake and new load SHALL replace out_gray with the new word, with out_valid staying 1 and no bubble.
REQ-019 While out_valid && !out_ready, out_gray and out_valid SHALL hold stable.
REQ-020 Count mode: when cnt_en = 1 and the slot is free, the block SHALL load out_gray = gray(cnt_bin), set out_valid = 1, and increment cnt_bin on that edge.
REQ-021 cnt_bin SHALL wrap from 2^WIDTH-1 to 0 (WIDTH = 4: gray 1000 is followed by 0000).
REQ-022 In count mode in_valid and in_bin SHALL be ignored and in_ready SHALL be 0.
REQ-023 cnt_clr = 1 SHALL force cnt_bin = 0 after the edge and has priority over increment.
REQ-024 When cnt_clr and a count-mode load coincide, the loaded word SHALL be gray(old cnt_bin) and cnt_bin SHALL become 0.
REQ-025 A change of cnt_en SHALL affect only new loads; a held output word SHALL be unaffected.
REQ-026 cnt_bin SHALL not change in stream mode except by cnt_clr.
REQ-027 Mode control: a 2-state FSM SHALL select the source, STREAM (cnt_en = 0) or COUNT (cnt_en = 1). Its transitions SHALL follow cnt_en each cycle with no extra latency.

Reset
REQ-028 While rst = 1 at an edge, the block SHALL set out_valid = 0, out_gray = 0, cnt_bin = 0 and FSM = STREAM; in_ready SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held word; the word SHALL not reappear after reset.
REQ-030 The first acceptance SHALL be possible in the first cycle with rst = 0.

Verification (WIDTH = 4)
REQ-031 Stream in_bin 0..9 back-to-back with out_ready = 1 -> out_gray 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101, each 1 cycle after acceptance, with no gaps.
REQ-032 Backpressure: accept 0101, hold out_ready = 0 for 3 cycles while offering 1010 -> out_gray = 0111 stable, in_ready = 0; on release 0111 is taken, then 1111 appears the next cycle.
REQ-033 Count wrap: cnt_en = 1, out_ready = 1 for 17 cycles -> 16 Gray codes 0000..1000 in order, then 0000; cnt_bin wraps 15 -> 0; each consecutive pair differs in exactly 1 bit.
REQ-034 cnt_clr pulse when cnt_bin = 6 in count mode -> loaded word 0101 (gray of 6), cnt_bin = 0, next word 0000.
REQ-035 cnt_en rises in the same cycle as in_valid with in_bin = 0011 -> in_ready = 0, word not accepted, output = gray(cnt_bin).
REQ-036 rst pulse while out_valid = 1 and out_ready = 0 -> out_valid = 0, out_gray = 0000, cnt_bin = 0 next cycle; the held word is never delivered.

Source files
------------

// File: rtl/bin_to_gray_stream.sv
// Binary-to-Gray converter with a one-stage valid/ready output register.
// The source word comes from in_bin (stream mode) or from an internal wrapping counter (count mode).
module bin_to_gray_stream #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_bin,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_gray,
    input  logic             out_ready,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] cnt_bin
);

    typedef enum logic {
        ST_STREAM = 1'b0,
        ST_COUNT  = 1'b1
    } mode_t;

    mode_t            r_state;
    mode_t            w_state_next;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_gray;
    logic [WIDTH-1:0] r_cnt;
    logic             w_slot_free;
    logic             w_count_mode;
    logic             w_load;
    logic             w_cnt_inc;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_gray;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STREAM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The mode in force this cycle is the next state, so a cnt_en change
    // selects the new source on the very same edge.
    always_comb begin
        w_state_next = r_state;
        w_count_mode = 1'b0;
        w_load       = 1'b0;
        w_cnt_inc    = 1'b0;
        in_ready     = 1'b0;
        case (r_state)
            ST_STREAM: if (cnt_en)  w_state_next = ST_COUNT;
            ST_COUNT:  if (!cnt_en) w_state_next = ST_STREAM;
            default:   w_state_next = ST_STREAM;
        endcase
        w_count_mode = (w_state_next == ST_COUNT);
        if (!rst && w_slot_free) begin
            if (w_count_mode) begin
                w_load    = 1'b1;
                w_cnt_inc = 1'b1;
            end else begin
                in_ready = 1'b1;
                w_load   = in_valid;
            end
        end
    end

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_src       = w_count_mode ? r_cnt : in_bin;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign w_gray[gi] = w_src[gi] ^ w_src[gi+1];
        end
    endgenerate
    assign w_gray[WIDTH-1] = w_src[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_gray  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_gray  <= w_gray;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Clear wins over increment; a coinciding load still uses the old count.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_gray  = r_out_gray;
    assign cnt_bin   = r_cnt;

endmodule

// File: tb/tb_bin_to_gray_stream.sv
// Directed bench for bin_to_gray_stream (WIDTH = 4): vector table for streaming,
// hand-written sequences for backpressure, count wrap, clear, mode switch and reset.
module tb_bin_to_gray_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_bin;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_gray;
    logic       out_ready;
    logic       cnt_en;
    logic       cnt_clr;
    logic [3:0] cnt_bin;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
    } vec_t;

    vec_t       vecs[10];
    logic [3:0] cnt_gray[16];
    logic [3:0] prev_gray;

    bin_to_gray_stream #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bin    (in_bin),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_gray  (out_gray),
        .out_ready (out_ready),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .cnt_bin   (cnt_bin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'd0, 4'b0000};
        vecs[1] = '{4'd1, 4'b0001};
        vecs[2] = '{4'd2, 4'b0011};
        vecs[3] = '{4'd3, 4'b0010};
        vecs[4] = '{4'd4, 4'b0110};
        vecs[5] = '{4'd5, 4'b0111};
        vecs[6] = '{4'd6, 4'b0101};
        vecs[7] = '{4'd7, 4'b0100};
        vecs[8] = '{4'd8, 4'b1100};
        vecs[9] = '{4'd9, 4'b1101};
        cnt_gray = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Reset state
        rst = 1'b1; in_valid = 1'b1; in_bin = 4'd7; out_ready = 1'b1;
        cnt_en = 1'b0; cnt_clr = 1'b0;
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_gray", {28'd0, out_gray}, 32'd0);
        check("rst_cnt_bin", {28'd0, cnt_bin}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);

        // Streaming 0..9 back-to-back, first acceptance in first cycle out of reset
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_bin = vecs[i].bin;
            #1;
            check($sformatf("stream_in_ready[%0d]", i), {31'd0, in_ready}, 32'd1);
            step();
            check($sformatf("stream_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream_gray[%0d]", i), {28'd0, out_gray}, {28'd0, vecs[i].gray});
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("stream_cnt_hold", {28'd0, cnt_bin}, 32'd0);

        // Backpressure
        in_valid = 1'b1; in_bin = 4'b0101;
        step();
        check("bp_load", {28'd0, out_gray}, 32'b0111);
        out_ready = 1'b0; in_bin = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_in_ready[%0d]", i), {31'd0, in_ready}, 32'd0);
            step();
            check($sformatf("bp_hold_gray[%0d]", i), {28'd0, out_gray}, 32'b0111);
            check($sformatf("bp_hold_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_next_gray", {28'd0, out_gray}, 32'b1111);
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);

        // Count mode with wrap
        cnt_en = 1'b1; in_valid = 1'b1; in_bin = 4'b1111;
        #1;
        check("cnt_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            step();
            check($sformatf("cnt_gray[%0d]", i), {28'd0, out_gray}, {28'd0, cnt_gray[i % 16]});
            check($sformatf("cnt_bin[%0d]", i), {28'd0, cnt_bin}, (i + 1) % 16);
            if (i > 0)
                check($sformatf("cnt_onebit[%0d]", i), $countones(out_gray ^ prev_gray), 32'd1);
            prev_gray = out_gray;
        end
        in_valid = 1'b0;

        // Advance to cnt_bin = 6, then clear coinciding with a load
        for (int i = 0; i < 16 && cnt_bin != 4'd6; i++) step();
        check("clr_pre_cnt", {28'd0, cnt_bin}, 32'd6);
        cnt_clr = 1'b1;
        step();
        check("clr_loaded_gray", {28'd0, out_gray}, 32'b0101);
        check("clr_cnt_zero", {28'd0, cnt_bin}, 32'd0);
        cnt_clr = 1'b0;
        step();
        check("clr_next_gray", {28'd0, out_gray}, 32'b0000);
        check("clr_next_cnt", {28'd0, cnt_bin}, 32'd1);

        // Back to stream mode, then cnt_en rises together with in_valid
        cnt_en = 1'b0;
        step();
        check("sw_stream_valid", {31'd0, out_valid}, 32'd0);
        check("sw_stream_cnt", {28'd0, cnt_bin}, 32'd1);
        cnt_en = 1'b1; in_valid = 1'b1; in_bin = 4'b0011;
        #1;
        check("sw_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("sw_gray", {28'd0, out_gray}, 32'b0001);
        check("sw_cnt", {28'd0, cnt_bin}, 32'd2);

        // Held word unaffected by mode change
        out_ready = 1'b0; cnt_en = 1'b0;
        step();
        cnt_en = 1'b1;
        step();
        check("hold_mode_gray", {28'd0, out_gray}, 32'b0001);
        check("hold_mode_cnt", {28'd0, cnt_bin}, 32'd2);
        check("hold_mode_valid", {31'd0, out_valid}, 32'd1);

        // Reset while a word is held
        cnt_en = 1'b0; in_valid = 1'b0; rst = 1'b1;
        step();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_gray", {28'd0, out_gray}, 32'd0);
        check("midrst_cnt", {28'd0, cnt_bin}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
